// File: rtl/adc_scan_sequencer.sv
// adc_scan_sequencer: periodic masked ADC channel scanner with response timeout and overrun detection
module adc_scan_sequencer #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [7:0]  chan_mask,
  input  logic [15:0] period,
  output logic [23:0] adc_data,
  output logic        adc_wr,
  input  logic [23:0] adc_rd_data,
  input  logic        adc_rd_valid,
  input  logic [2:0]  rd_addr,
  output logic [9:0]  rd_data,
  output logic [7:0]  result_valid,
  output logic        scan_done,
  output logic        err_timeout,
  output logic        err_overrun,
  input  logic        err_clr,
  output logic        busy
);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, NEXT, HOLD} state_t;
  state_t          state_q;
  logic [7:0]      rem_q;
  logic [2:0]      ch_q;
  logic [2:0]      adc_ch_q;
  logic [TW-1:0]   wcnt_q;
  logic [15:0]     pcnt_q;
  logic [9:0]      res_q [8];
  logic [7:0]      valid_q;
  logic            adc_wr_q;
  logic            scan_done_q;
  logic            busy_q;
  logic            err_t_q;
  logic            err_o_q;
  logic            hit;
  logic            tmo;
  logic            due;
  logic            go_scan;
  logic            go_next;
  logic [7:0]      src;
  logic [2:0]      pick;
  logic [16:0]     pnext;
  logic            unused_bits;

  function automatic logic [2:0] lowest(input logic [7:0] m);
    lowest = 3'd0;
    for (int i = 7; i >= 0; i--) if (m[i]) lowest = 3'(i);
  endfunction

  assign hit         = adc_rd_valid && adc_rd_data[23:16] == {5'b0, ch_q};
  assign tmo         = wcnt_q == TW'(TIMEOUT - 1);
  assign pnext       = {1'b0, pcnt_q} + 17'd1;
  // due: the edge ending this cycle is at least period cycles after scan start
  assign due         = pnext >= {1'b0, period};
  assign go_scan     = en && chan_mask != 8'd0 && (state_q == IDLE || (state_q == HOLD && due));
  assign go_next     = state_q == NEXT && en && rem_q != 8'd0;
  assign src         = go_scan ? chan_mask : rem_q;
  assign pick        = lowest(src);
  assign unused_bits = ^adc_rd_data[15:10];

  assign adc_data     = {21'b0, adc_ch_q};
  assign adc_wr       = adc_wr_q;
  assign scan_done    = scan_done_q;
  assign busy         = busy_q;
  assign result_valid = valid_q;
  assign err_timeout  = err_t_q;
  assign err_overrun  = err_o_q;
  assign rd_data      = res_q[rd_addr];

  // Scan control: channel issue, response/timeout handling, period pacing and sticky errors
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rem_q       <= 8'd0;
      ch_q        <= 3'd0;
      adc_ch_q    <= 3'd0;
      wcnt_q      <= '0;
      pcnt_q      <= 16'd0;
      valid_q     <= 8'd0;
      adc_wr_q    <= 1'b0;
      scan_done_q <= 1'b0;
      busy_q      <= 1'b0;
      err_t_q     <= 1'b0;
      err_o_q     <= 1'b0;
    end else begin
      adc_wr_q    <= 1'b0;
      scan_done_q <= 1'b0;
      pcnt_q      <= pcnt_q == 16'hFFFF ? pcnt_q : pcnt_q + 16'd1;
      if (err_clr) begin
        err_t_q <= 1'b0;
        err_o_q <= 1'b0;
      end
      case (state_q)
        IDLE: ;
        ISSUE: begin
          state_q <= WAIT;
          wcnt_q  <= '0;
        end
        WAIT: begin
          if (hit || tmo) begin
            state_q       <= NEXT;
            valid_q[ch_q] <= hit;
            if (!hit) err_t_q <= 1'b1;
          end else begin
            wcnt_q <= wcnt_q + TW'(1);
          end
        end
        NEXT: begin
          if (!en) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (rem_q == 8'd0) begin
            state_q     <= HOLD;
            scan_done_q <= 1'b1;
            if (period != 16'd0 && due) err_o_q <= 1'b1;
          end
        end
        HOLD: begin
          if (!go_scan && (!en || due)) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
      if (go_scan || go_next) begin
        state_q  <= ISSUE;
        busy_q   <= 1'b1;
        adc_wr_q <= 1'b1;
        adc_ch_q <= pick;
        ch_q     <= pick;
        rem_q    <= src & ~(8'd1 << pick);
        if (go_scan) pcnt_q <= 16'd0;
      end
    end
  end

  // Result capture on a matching response; storage is deliberately not reset
  always_ff @(posedge clk) begin
    if (state_q == WAIT && hit) res_q[ch_q] <= adc_rd_data[9:0];
  end
endmodule

// File: tb/tb_adc_scan_sequencer.sv
// tb_adc_scan_sequencer: directed and randomized checks against a timeline model of the scan sequencer
module tb_adc_scan_sequencer;
  localparam int TIMEOUT = 255;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        err_clr = 1'b0;
  logic        adc_rd_valid = 1'b0;
  logic [7:0]  chan_mask = 8'd0;
  logic [15:0] period = 16'd0;
  logic [23:0] adc_rd_data = 24'd0;
  logic [2:0]  rd_addr = 3'd0;
  logic [23:0] adc_data;
  logic        adc_wr;
  logic        scan_done;
  logic        err_timeout;
  logic        err_overrun;
  logic        busy;
  logic [9:0]  rd_data;
  logic [7:0]  result_valid;

  adc_scan_sequencer #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .en(en), .chan_mask(chan_mask), .period(period),
    .adc_data(adc_data), .adc_wr(adc_wr), .adc_rd_data(adc_rd_data), .adc_rd_valid(adc_rd_valid),
    .rd_addr(rd_addr), .rd_data(rd_data), .result_valid(result_valid), .scan_done(scan_done),
    .err_timeout(err_timeout), .err_overrun(err_overrun), .err_clr(err_clr), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  // expected outputs after each edge, derived from a scan timeline
  logic        m_wr = 1'b0;
  logic        m_done = 1'b0;
  logic        m_busy = 1'b0;
  logic        m_et = 1'b0;
  logic        m_eo = 1'b0;
  logic [23:0] m_data = 24'd0;
  logic [7:0]  m_valid = 8'd0;
  logic [9:0]  m_res [8];
  int          mcyc = 0;

  task automatic step(output bit ab);
    @(posedge clk or posedge rst);
    ab = rst;
    if (!ab) begin
      m_wr = 1'b0;
      m_done = 1'b0;
      mcyc++;
      if (err_clr) begin
        m_et = 1'b0;
        m_eo = 1'b0;
      end
    end
  endtask

  task automatic run();
    bit ab;
    bit idle;
    bit got;
    logic [7:0] m;
    int st;
    forever begin
      m_busy = 1'b0;
      do begin
        step(ab);
        if (ab) return;
      end while (!(en && chan_mask != 8'd0));
      forever begin
        m = chan_mask;
        st = mcyc;
        idle = 1'b0;
        for (int c = 0; c < 8; c++) begin
          if (!m[c]) continue;
          m_wr = 1'b1;
          m_data = 24'(c);
          m_busy = 1'b1;
          step(ab);
          if (ab) return;
          got = 1'b0;
          for (int w = 0; w < TIMEOUT && !got; w++) begin
            step(ab);
            if (ab) return;
            if (adc_rd_valid && adc_rd_data[23:16] == 8'(c)) begin
              m_res[c] = adc_rd_data[9:0];
              m_valid[c] = 1'b1;
              got = 1'b1;
            end
          end
          if (!got) begin
            m_et = 1'b1;
            m_valid[c] = 1'b0;
          end
          step(ab);
          if (ab) return;
          if (!en) begin
            idle = 1'b1;
            break;
          end
        end
        if (idle) break;
        m_done = 1'b1;
        if (period != 16'd0 && mcyc + 1 - st > int'(period)) m_eo = 1'b1;
        do begin
          step(ab);
          if (ab) return;
        end while (en && mcyc - st < int'(period));
        if (!en || chan_mask == 8'd0) break;
      end
    end
  endtask

  initial forever begin
    m_wr = 1'b0;
    m_done = 1'b0;
    m_busy = 1'b0;
    m_et = 1'b0;
    m_eo = 1'b0;
    m_data = 24'd0;
    m_valid = 8'd0;
    wait (!rst);
    run();
  end

  // per-cycle comparison and event log
  int       tcyc = 0;
  int       nw = 0;
  int       nd = 0;
  int       wr_t [4096];
  logic [2:0] wr_d [4096];

  always @(posedge clk) tcyc++;

  always @(negedge clk) begin
    chk("adc_wr", adc_wr, m_wr);
    chk("adc_data", adc_data, m_data);
    chk("scan_done", scan_done, m_done);
    chk("busy", busy, m_busy);
    chk("result_valid", result_valid, m_valid);
    chk("err_timeout", err_timeout, m_et);
    chk("err_overrun", err_overrun, m_eo);
    if (m_valid[rd_addr]) chk("rd_data", rd_data, m_res[rd_addr]);
    if (adc_wr && nw < 4096) begin
      wr_t[nw] = tcyc;
      wr_d[nw] = adc_data[2:0];
      nw++;
    end
    if (scan_done) nd++;
  end

  // ADC responder: answers each request after rdly cycles with tag=ch
  int         rdly = 20;
  int         roff = 0;
  logic [7:0] rsil = 8'd0;
  bit         rwrong = 1'b0;
  bit         rspur = 1'b0;

  initial begin
    int rc;
    int due;
    bit pend;
    logic [7:0] rch;
    rc = 0;
    due = 0;
    pend = 1'b0;
    rch = 8'd0;
    forever begin
      @(posedge clk);
      #2;
      rc++;
      adc_rd_valid = 1'b0;
      adc_rd_data = 24'($urandom);
      if (adc_wr) begin
        pend = 1'b1;
        rch = adc_data[7:0];
        due = rc + rdly;
      end
      if (pend && rwrong && rc == due - 2) begin
        adc_rd_valid = 1'b1;
        adc_rd_data = {rch + 8'h10, 6'b0, 10'h3FF};
      end else if (pend && rc == due) begin
        pend = 1'b0;
        if (!rsil[rch[2:0]]) begin
          adc_rd_valid = 1'b1;
          adc_rd_data = {rch, 6'b0, 10'(int'(rch) * 10 + roff + int'(rwrong))};
        end
      end else if (rspur && $urandom_range(0, 15) == 0) begin
        adc_rd_valid = 1'b1;
      end
    end
  end

  bit rnd = 1'b0;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
      if (rnd) begin
        rd_addr = 3'($urandom);
        err_clr = $urandom_range(0, 39) == 0;
      end
    end
  endtask

  task automatic wait_wr(input int n, input int lim, input string nm);
    int k;
    k = 0;
    while (nw < n && k < lim) begin
      tick();
      k++;
    end
    chk(nm, nw >= n, 1);
  endtask

  initial begin
    int b;
    int nd0;
    tick(3);
    rst = 1'b0;
    tick(2);
    chk("reset_busy", busy, 0);
    chk("reset_valid", result_valid, 0);
    chk("reset_data", adc_data, 0);

    // two-channel scan with 100-cycle period
    b = nw;
    nd0 = nd;
    period = 16'd100;
    chan_mask = 8'h05;
    rdly = 20;
    en = 1'b1;
    wait_wr(b + 3, 400, "t1_wait");
    chk("t1_first_ch", wr_d[b], 0);
    chk("t1_second_ch", wr_d[b + 1], 2);
    chk("t1_ch_gap", wr_t[b + 1] - wr_t[b], 22);
    chk("t1_period", wr_t[b + 2] - wr_t[b], 100);
    chk("t1_done_once", nd - nd0, 1);
    chk("t1_valid", result_valid, 8'h05);
    rd_addr = 3'd0;
    #1 chk("t1_res0", rd_data, 0);
    rd_addr = 3'd2;
    #1 chk("t1_res2", rd_data, 20);
    en = 1'b0;
    tick(300);

    // silent channel 1 times out
    b = nw;
    rsil = 8'h02;
    chan_mask = 8'h06;
    period = 16'd1000;
    en = 1'b1;
    wait_wr(b + 2, 400, "t2_wait");
    chk("t2_timeout_gap", wr_t[b + 1] - wr_t[b], 257);
    chk("t2_next_ch", wr_d[b + 1], 2);
    chk("t2_err_timeout", err_timeout, 1);
    chk("t2_valid1", result_valid[1], 0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    tick();
    chk("t2_err_clr", err_timeout, 0);
    en = 1'b0;
    rsil = 8'd0;
    tick(300);

    // full mask with short period overruns
    b = nw;
    rdly = 3;
    chan_mask = 8'hFF;
    period = 16'd10;
    en = 1'b1;
    wait_wr(b + 10, 400, "t3_wait");
    chk("t3_overrun", err_overrun, 1);
    chk("t3_step", wr_t[b + 1] - wr_t[b], 5);
    chk("t3_wrap", wr_t[b + 8] - wr_t[b + 7], 6);
    chk("t3_wrap_ch", wr_d[b + 8], 0);
    en = 1'b0;
    tick(100);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;

    // wrong tag precedes the correct one
    b = nw;
    nd0 = nd;
    rdly = 20;
    rwrong = 1'b1;
    chan_mask = 8'h0A;
    period = 16'd200;
    en = 1'b1;
    wait_wr(b + 2, 200, "t4_wait");
    tick(30);
    chk("t4_requests", nw - b, 2);
    chk("t4_done", nd - nd0, 1);
    rd_addr = 3'd1;
    #1 chk("t4_res1", rd_data, 11);
    rd_addr = 3'd3;
    #1 chk("t4_res3", rd_data, 31);
    en = 1'b0;
    rwrong = 1'b0;
    tick(10);

    // enable dropped while channel 3 is outstanding
    b = nw;
    nd0 = nd;
    chan_mask = 8'h0F;
    period = 16'd500;
    en = 1'b1;
    wait_wr(b + 4, 300, "t5_wait");
    chk("t5_ch3", wr_d[b + 3], 3);
    tick(5);
    en = 1'b0;
    tick(60);
    chk("t5_requests", nw - b, 4);
    chk("t5_no_done", nd - nd0, 0);
    chk("t5_busy", busy, 0);
    chk("t5_valid3", result_valid[3], 1);

    // reset in the middle of a wait, then a late response
    b = nw;
    chan_mask = 8'h01;
    en = 1'b1;
    wait_wr(b + 1, 50, "t6_wait");
    tick(5);
    rst = 1'b1;
    en = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(30);
    chk("t6_valid", result_valid, 0);
    chk("t6_busy", busy, 0);
    chk("t6_requests", nw - b, 1);
    chk("t6_err_timeout", err_timeout, 0);
    chk("t6_data", adc_data, 0);

    // empty mask never starts a scan
    b = nw;
    nd0 = nd;
    chan_mask = 8'h00;
    en = 1'b1;
    tick(20);
    chk("t7_requests", nw - b, 0);
    chk("t7_busy", busy, 0);
    chk("t7_done", nd - nd0, 0);
    en = 1'b0;

    // randomized segments
    rnd = 1'b1;
    rspur = 1'b1;
    for (int s = 0; s < 24; s++) begin
      chan_mask = $urandom_range(0, 9) == 0 ? 8'd0 : 8'($urandom);
      period = $urandom_range(0, 3) == 0 ? 16'd0 : 16'($urandom_range(1, 300));
      rdly = $urandom_range(1, 30);
      roff = $urandom_range(0, 50);
      rwrong = $urandom_range(0, 3) == 0;
      rsil = $urandom_range(0, 5) == 0 ? 8'd1 << $urandom_range(0, 7) : 8'd0;
      en = $urandom_range(0, 4) != 0;
      if ($urandom_range(0, 7) == 0) begin
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
      end
      tick($urandom_range(100, 500));
    end
    rnd = 1'b0;
    rspur = 1'b0;
    err_clr = 1'b0;
    tick(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
